// File: rtl/sm_als_avg.sv
// Ambient-light sensor moving average over a 2^DEPTH_LOG2 sample window,
// with a hysteresis "bright" comparator on each new average.
module sm_als_avg #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    input  logic [15:0] thr_hi,
    input  logic [15:0] thr_lo,
    output logic        avg_valid,
    output logic        avg_strobe,
    output logic        bright,
    output logic [31:0] value
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SUM_W = 16 + DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [15:0]            ring [DEPTH];
    logic [DEPTH_LOG2-1:0]  ptr;
    logic [CNT_W-1:0]       count;
    logic [SUM_W-1:0]       sum;
    logic [SUM_W-1:0]       sum_next;
    logic [15:0]            avg;
    logic [15:0]            avg_next;
    logic                   accept;
    logic                   update;
    logic                   bright_next;

    // Next-state, running-sum and comparator logic
    always_comb begin
        state_next  = state;
        sum_next    = sum;
        update      = 1'b0;
        accept      = sample_valid && !clr;
        case (state)
            FILL: begin
                if (accept) begin
                    sum_next = sum + SUM_W'(sample);
                    if (count == CNT_W'(DEPTH - 1)) begin
                        state_next = RUN;
                        update     = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    sum_next = sum - SUM_W'(ring[ptr]) + SUM_W'(sample);
                    update   = 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
        if (clr) begin
            state_next = FILL;
        end
        avg_next = 16'(sum_next >> DEPTH_LOG2);
        // Set wins over clear when the thresholds overlap
        if (avg_next >= thr_hi) begin
            bright_next = 1'b1;
        end else if (avg_next <= thr_lo) begin
            bright_next = 1'b0;
        end else begin
            bright_next = bright;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            ptr        <= '0;
            count      <= '0;
            sum        <= '0;
            avg        <= '0;
            avg_valid  <= 1'b0;
            avg_strobe <= 1'b0;
            bright     <= 1'b0;
        end else begin
            state      <= state_next;
            avg_strobe <= update;
            if (clr) begin
                ptr       <= '0;
                count     <= '0;
                sum       <= '0;
                avg       <= '0;
                avg_valid <= 1'b0;
                bright    <= 1'b0;
            end else begin
                if (accept) begin
                    ptr <= ptr + DEPTH_LOG2'(1);
                    sum <= sum_next;
                    if (state == FILL) begin
                        count <= count + CNT_W'(1);
                    end
                end
                if (update) begin
                    avg       <= avg_next;
                    bright    <= bright_next;
                    avg_valid <= 1'b1;
                end
            end
        end
    end

    // Sample storage needs no reset: every entry is rewritten during FILL
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            ring[ptr] <= sample;
        end
    end

    assign value = {bright, 15'b0, avg};

endmodule

// File: tb/tb_sm_als_avg.sv
// Bench for sm_als_avg: directed scenarios plus random traffic, compared
// against a queue-based sliding-window model.
module tb_sm_als_avg;

    localparam int unsigned L     = 3;
    localparam int unsigned DEPTH = 1 << L;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = '0;
    logic [15:0] thr_hi = 16'd500;
    logic [15:0] thr_lo = 16'd300;
    logic        avg_valid;
    logic        avg_strobe;
    logic        bright;
    logic [31:0] value;

    int checks   = 0;
    int failures = 0;

    int unsigned win[$];
    logic        m_valid  = 1'b0;
    logic        m_strobe = 1'b0;
    logic        m_bright = 1'b0;
    logic [15:0] m_avg    = '0;

    sm_als_avg #(.DEPTH_LOG2(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .sample_valid (sample_valid),
        .sample       (sample),
        .thr_hi       (thr_hi),
        .thr_lo       (thr_lo),
        .avg_valid    (avg_valid),
        .avg_strobe   (avg_strobe),
        .bright       (bright),
        .value        (value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: the window is simply the last DEPTH accepted samples
    task automatic model_step(input logic v, input logic [15:0] s, input logic c, input logic r);
        longint unsigned total;
        m_strobe = 1'b0;
        if (r || c) begin
            win.delete();
            m_valid  = 1'b0;
            m_bright = 1'b0;
            m_avg    = '0;
        end else if (v) begin
            win.push_back(32'(s));
            if (win.size() > DEPTH) void'(win.pop_front());
            if (win.size() == DEPTH) begin
                total = 0;
                foreach (win[i]) total += win[i];
                m_avg    = 16'(total / DEPTH);
                m_strobe = 1'b1;
                m_valid  = 1'b1;
                if (m_avg >= thr_hi) m_bright = 1'b1;
                else if (m_avg <= thr_lo) m_bright = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] s, input logic c, input logic r);
        @(negedge clk);
        sample_valid = v;
        sample       = s;
        clr          = c;
        rst          = r;
        @(posedge clk);
        model_step(v, s, c, r);
        #1;
        check("avg_valid",  32'(avg_valid),  32'(m_valid));
        check("avg_strobe", 32'(avg_strobe), 32'(m_strobe));
        check("bright",     32'(bright),     32'(m_bright));
        check("value",      value,           {m_bright, 15'b0, m_avg});
    endtask

    task automatic feed(input int n, input logic [15:0] s);
        for (int i = 0; i < n; i++) cycle(1'b1, s, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] rs;
        logic        rv;
        logic        rc;
        logic        rr;

        cycle(1'b0, 16'd0, 1'b0, 1'b1);
        check("reset_value", value, 32'h0);
        cycle(1'b0, 16'd0, 1'b0, 1'b0);

        // Fill with 100: strobe only after the eighth sample
        feed(7, 16'd100);
        check("fill_no_strobe", 32'(avg_strobe), 32'h0);
        check("fill_value_zero", value, 32'h0);
        feed(1, 16'd100);
        check("first_strobe", 32'(avg_strobe), 32'h1);
        check("first_value", value, 32'h0000_0064);

        // Replacement and pointer wrap
        feed(1, 16'd900);
        check("avg_200", value, 32'h0000_00C8);
        feed(7, 16'd900);
        check("avg_900", value, 32'h8000_0384);

        // Hysteresis walk: 200 -> 600 -> 400 -> 250
        cycle(1'b0, 16'd0, 1'b1, 1'b0);
        feed(8, 16'd200);
        check("hys_200", 32'(bright), 32'h0);
        feed(8, 16'd600);
        check("hys_600", value, 32'h8000_0258);
        feed(8, 16'd400);
        check("hys_400", value, 32'h8000_0190);
        feed(8, 16'd250);
        check("hys_250", value, 32'h0000_00FA);

        // Full-scale window, back to back
        cycle(1'b0, 16'd0, 1'b1, 1'b0);
        feed(8, 16'hFFFF);
        check("max_avg", value, 32'h8000_FFFF);

        // clr together with a sample in RUN: sample dropped, full refill needed
        cycle(1'b1, 16'd7, 1'b1, 1'b0);
        check("clr_valid", 32'(avg_valid), 32'h0);
        check("clr_value", value, 32'h0);
        feed(7, 16'd40);
        check("clr_refill_no_strobe", 32'(avg_strobe), 32'h0);
        feed(1, 16'd40);
        check("clr_refill_strobe", value, 32'h0000_0028);

        // rst mid-window discards partial accumulation
        cycle(1'b0, 16'd0, 1'b1, 1'b0);
        feed(5, 16'd1000);
        cycle(1'b0, 16'd0, 1'b0, 1'b1);
        check("rst_mid_value", value, 32'h0);
        check("rst_mid_valid", 32'(avg_valid), 32'h0);
        feed(8, 16'd50);
        check("rst_fresh_avg", value, 32'h0000_0032);

        // Random traffic with occasional clr/rst and threshold changes
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                thr_hi = 16'($urandom_range(200, 900));
                thr_lo = 16'($urandom_range(100, 800));
            end
            rr = ($urandom_range(0, 149) == 0);
            rc = ($urandom_range(0, 79) == 0);
            rv = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(100, 1000));
            cycle(rv, rs, rc, rr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_als_avg.md
SM_ALS_AVG -- requirements
Module: sm_als_avg

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, meaning averaging window of 2^DEPTH_LOG2 samples (legal range 1..5).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port clr, input, 1 bit: synchronous restart of averaging; thresholds unaffected.
REQ-005 SHALL have port sample_valid, input, 1 bit: one-cycle strobe qualifying sample.
REQ-006 SHALL have port sample, input, 16 bits: raw light-sensor reading, unsigned.
REQ-007 SHALL have port thr_hi, input, 16 bits: bright-set threshold, unsigned.
REQ-008 SHALL have port thr_lo, input, 16 bits: bright-clear threshold, unsigned.
REQ-009 SHALL have port avg_valid, output, 1 bit: high once the window is full.
REQ-010 SHALL have port avg_strobe, output, 1 bit: one-cycle pulse on each avg update.
REQ-011 SHALL have port bright, output, 1 bit: hysteresis comparator flag.
REQ-012 SHALL have port value, output, 32 bits: {bright, 15'b0, avg[15:0]}, for the memory-mapped read path.

Function
REQ-013 SHALL hold a ring buffer of 2^DEPTH_LOG2 16-bit entries, a DEPTH_LOG2-bit write pointer that wraps modulo depth, and a (16+DEPTH_LOG2)-bit running sum.
REQ-014 SHALL run a two-state FSM: FILL (window not yet full) and RUN (window full).
REQ-015 On sample_valid in FILL: write sample at pointer, sum += sample, pointer += 1, fill count += 1; on the sample that makes the count reach 2^DEPTH_LOG2, go to RUN.
REQ-016 On sample_valid in RUN: sum = sum - buf[ptr] + sample, write sample to buf[ptr], pointer += 1 (wrap from depth-1 to 0).
REQ-017 SHALL compute avg = sum >> DEPTH_LOG2 (truncating); the sum never overflows by construction.
REQ-018 avg, avg_strobe, and bright SHALL update exactly 1 cycle after the sample_valid edge that caused them; avg_strobe SHALL pulse only for samples accepted in RUN, including the filling sample.
REQ-019 avg_valid SHALL rise in the same cycle as the first avg_strobe and stay high until rst or clr.
REQ-020 Hysteresis, evaluated only on avg_strobe with the new avg: if avg >= thr_hi, bright = 1; else if avg <= thr_lo, bright = 0; else hold.
REQ-021 If thr_lo >= thr_hi and both conditions hold, set SHALL take priority.
REQ-022 In FILL, value[15:0] SHALL read 0 and bright SHALL stay 0.
REQ-023 Back-to-back sample_valid on consecutive cycles SHALL be accepted every cycle with no loss.
REQ-024 clr SHALL return the block to FILL next cycle: sum = 0, pointer = 0, count = 0, avg = 0, avg_valid = 0, bright = 0; buffer contents need not be cleared.
REQ-025 If clr and sample_valid are asserted together, clr SHALL win and the sample SHALL be discarded.
REQ-026 The sample_valid, sample, and thr_* inputs are in the clk domain; the block SHALL add no synchronizers.

Reset
REQ-027 rst SHALL take priority over clr and sample_valid.
REQ-028 After rst: FSM = FILL, sum = 0, pointer = 0, count = 0, avg_valid = 0, avg_strobe = 0, bright = 0, value = 32'h0.
REQ-029 Reset asserted mid-window SHALL discard all partial accumulation; the first post-reset average SHALL need a full 2^DEPTH_LOG2 fresh samples.

Verification
REQ-030 DEPTH_LOG2=3: feed 8 samples of 16'd100 -> avg_valid and avg_strobe rise 1 cycle after the 8th sample; value = 32'h0000_0064; no strobe on samples 1-7.
REQ-031 Window full of 100, then one sample of 900 -> avg = (7*100+900)>>3 = 200; 7 more samples of 900 -> avg = 900, confirming the pointer wrap.
REQ-032 thr_hi = 500, thr_lo = 300: avg sequence 200, 600, 400, 250 -> bright = 0, 1, 1, 0; value[31] tracks bright.
REQ-033 Eight samples of 16'hFFFF on back-to-back cycles -> avg = 16'hFFFF with no overflow and 1 strobe (on the last sample).
REQ-034 clr and sample_valid asserted together mid-RUN -> next cycle avg_valid = 0 and value = 0; 8 further samples are needed before the next strobe.
REQ-035 rst asserted in the cycle after the 5th sample, then released -> all outputs 0; the avg over the next 8 samples excludes the pre-reset samples.
